// File: rtl/mcpu_seq_alu.sv
// Registered, handshaked ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL.
// Logic/arith/shift results appear one cycle after accept; MUL takes WORD_SIZE+1 cycles; start is ignored while busy.
module mcpu_seq_alu #(
  parameter int WORD_SIZE  = 16,
  parameter int CMD_SIZE   = 4,
  parameter int SHAMT_SIZE = $clog2(WORD_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CMD_SIZE-1:0]  cmd,
  input  logic [WORD_SIZE-1:0] in1,
  input  logic [WORD_SIZE-1:0] in2,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] out,
  output logic [WORD_SIZE-1:0] out_hi,
  output logic                 CF,
  output logic                 ZF,
  output logic                 NF,
  output logic                 VF,
  output logic                 err
);

  localparam logic [CMD_SIZE-1:0] OP_AND = CMD_SIZE'(0);
  localparam logic [CMD_SIZE-1:0] OP_OR  = CMD_SIZE'(1);
  localparam logic [CMD_SIZE-1:0] OP_XOR = CMD_SIZE'(2);
  localparam logic [CMD_SIZE-1:0] OP_ADD = CMD_SIZE'(3);
  localparam logic [CMD_SIZE-1:0] OP_LSL = CMD_SIZE'(4);
  localparam logic [CMD_SIZE-1:0] OP_LSR = CMD_SIZE'(5);
  localparam logic [CMD_SIZE-1:0] OP_SUB = CMD_SIZE'(6);
  localparam logic [CMD_SIZE-1:0] OP_MUL = CMD_SIZE'(7);
  localparam logic [CMD_SIZE-1:0] OP_ASR = CMD_SIZE'(8);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                     state_q;
  logic                       pend_q;
  logic [CMD_SIZE-1:0]        cmd_q;
  logic [WORD_SIZE-1:0]       a_q, b_q;
  logic [2*WORD_SIZE-1:0]     mcand_q, acc_q, acc_d;
  logic [WORD_SIZE-1:0]       mplier_q;
  logic [SHAMT_SIZE-1:0]      cnt_q;

  logic [CMD_SIZE-1:0]        sel_cmd;
  logic [WORD_SIZE-1:0]       sel_a, sel_b;
  logic [WORD_SIZE-1:0]       res_d;
  logic                       cf_d, vf_d, err_d;
  logic [SHAMT_SIZE-1:0]      sh;
  logic [WORD_SIZE:0]         wide_d;

  // An op accepted in the DONE cycle is parked and executed from IDLE so done pulses never merge.
  assign sel_cmd = pend_q ? cmd_q : cmd;
  assign sel_a   = pend_q ? a_q   : in1;
  assign sel_b   = pend_q ? b_q   : in2;
  assign sh      = sel_b[SHAMT_SIZE-1:0];
  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    res_d  = '0;
    cf_d   = 1'b0;
    vf_d   = 1'b0;
    err_d  = 1'b0;
    wide_d = '0;
    case (sel_cmd)
      OP_AND: res_d = sel_a & sel_b;
      OP_OR:  res_d = sel_a | sel_b;
      OP_XOR: res_d = sel_a ^ sel_b;
      OP_ADD: begin
        wide_d = {1'b0, sel_a} + {1'b0, sel_b};
        res_d  = wide_d[WORD_SIZE-1:0];
        cf_d   = wide_d[WORD_SIZE];
        vf_d   = (sel_a[WORD_SIZE-1] == sel_b[WORD_SIZE-1]) &&
                 (wide_d[WORD_SIZE-1] != sel_a[WORD_SIZE-1]);
      end
      OP_SUB: begin
        wide_d = {1'b0, sel_a} - {1'b0, sel_b};
        res_d  = wide_d[WORD_SIZE-1:0];
        cf_d   = wide_d[WORD_SIZE];
        vf_d   = (sel_a[WORD_SIZE-1] != sel_b[WORD_SIZE-1]) &&
                 (wide_d[WORD_SIZE-1] != sel_a[WORD_SIZE-1]);
      end
      // Shifts run one bit wider so the last bit shifted out lands in a fixed position.
      OP_LSL: begin
        wide_d = {1'b0, sel_a} << sh;
        res_d  = wide_d[WORD_SIZE-1:0];
        cf_d   = wide_d[WORD_SIZE];
      end
      OP_LSR: begin
        wide_d = {sel_a, 1'b0} >> sh;
        res_d  = wide_d[WORD_SIZE:1];
        cf_d   = wide_d[0];
      end
      OP_ASR: begin
        wide_d = $signed({sel_a, 1'b0}) >>> sh;
        res_d  = wide_d[WORD_SIZE:1];
        cf_d   = wide_d[0];
      end
      OP_MUL: res_d = '0;
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      cmd_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      out_hi   <= '0;
      CF       <= 1'b0;
      ZF       <= 1'b0;
      NF       <= 1'b0;
      VF       <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start || pend_q) begin
            pend_q <= 1'b0;
            if (sel_cmd == OP_MUL) begin
              mcand_q  <= {{WORD_SIZE{1'b0}}, sel_a};
              mplier_q <= sel_b;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy     <= 1'b1;
              state_q  <= S_MUL;
            end else begin
              out     <= res_d;
              out_hi  <= '0;
              CF      <= cf_d;
              VF      <= vf_d;
              ZF      <= (res_d == '0);
              NF      <= res_d[WORD_SIZE-1];
              err     <= err_d;
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHAMT_SIZE'(1);
          if (cnt_q == SHAMT_SIZE'(WORD_SIZE - 1)) begin
            out     <= acc_d[WORD_SIZE-1:0];
            out_hi  <= acc_d[2*WORD_SIZE-1:WORD_SIZE];
            CF      <= (acc_d[2*WORD_SIZE-1:WORD_SIZE] != '0);
            VF      <= (acc_d[2*WORD_SIZE-1:WORD_SIZE] != '0);
            ZF      <= (acc_d[WORD_SIZE-1:0] == '0);
            NF      <= acc_d[WORD_SIZE-1];
            err     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          err     <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            if (cmd == OP_MUL) begin
              mcand_q  <= {{WORD_SIZE{1'b0}}, in1};
              mplier_q <= in2;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy     <= 1'b1;
              state_q  <= S_MUL;
            end else begin
              cmd_q  <= cmd;
              a_q    <= in1;
              b_q    <= in2;
              pend_q <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
